// File: rtl/apb_stream_bridge_pkg.sv
// Shared definitions for the APB-to-stream bridge: register map, STATUS layout,
// slave FSM state type and the address decoder.
package apb_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8C00_0000;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CFG    = 2'd2;
  localparam logic [1:0] REG_FIFO   = 2'd3;

  localparam int unsigned STAT_FULL_BIT  = 5;
  localparam int unsigned STAT_EMPTY_BIT = 6;
  localparam int unsigned STAT_OVF_BIT   = 8;
  localparam logic [31:0] STATUS_W1C_MASK = 32'h0000_0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } apb_slave_state_t;

  typedef struct packed {
    logic       mapped;
    logic [1:0] idx;
  } reg_decode_t;

  // Four word registers starting at base; unaligned addresses count as unmapped.
  function automatic reg_decode_t decode_addr(input logic [31:0] addr,
                                              input logic [31:0] base);
    logic [31:0] off;
    reg_decode_t d;
    off      = addr - base;
    d.mapped = (off[31:4] == 28'd0) && (off[1:0] == 2'b00);
    d.idx    = off[3:2];
    return d;
  endfunction

endpackage

// File: rtl/apb_stream_bridge_sync_fifo.sv
// Synchronous FIFO with a registered head word. rst_n is an asynchronous,
// active-high reset. Pushes while full are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_en, pop_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign head_o  = head_q;
  assign level_o = level_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // The head register must already hold the next word when the pop lands;
    // with a single entry left, the only candidate is the word being pushed.
    if (pop_en) begin
      if (level_q > LW'(1))  head_d = mem_q[rd_ptr_d];
      else if (push_en)      head_d = wdata_i;
    end else if (push_en && empty_o) begin
      head_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/apb_stream_bridge.sv
// APB slave with CMD/STATUS/CFG registers and a write FIFO streamed downstream.
// rst_n is asynchronous, active-high. Define APB_SLVERR_EN to drive pslverr.
module apb_stream_bridge
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      paddr,
  input  logic [31:0]      pwdata,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [7:0]       cmd_o,
  output logic [31:0]      cfg_o,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output apb_slave_state_t state_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  apb_slave_state_t state_q, state_d;
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [31:0]      cfg_q, cfg_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             ovf_q, ovf_d;

  reg_decode_t      dec;
  logic             fifo_full, fifo_empty, fifo_push;
  logic [LW-1:0]    fifo_level;
  logic             is_fifo_wr, commit, drop;
  logic             wr_cmd, wr_status, wr_cfg, wr_fifo;
  logic [31:0]      status;

  assign dec        = decode_addr(paddr, BASE_ADDR);
  assign is_fifo_wr = psel & pwrite & dec.mapped & (dec.idx == REG_FIFO);

  // Slave FSM. SETUP is the cycle in which the access phase is expected; the
  // transfer completes on the cycle that moves the FSM into ACCESS, and ACCESS
  // then doubles as the slot for the next setup phase.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    pready      = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE, ACCESS: begin
        state_d = (psel && !penable) ? SETUP : IDLE;
      end
      SETUP: begin
        if (psel && penable) begin
          if (is_fifo_wr && fifo_full) begin
            state_d     = STALL;
            stall_cnt_d = CW'(1);
          end else begin
            pready  = 1'b1;
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (!(psel && penable)) begin
          state_d = IDLE;
        end else if (!fifo_full || stall_cnt_q == CW'(STALL_LIMIT)) begin
          pready  = 1'b1;
          drop    = fifo_full;
          state_d = ACCESS;
        end else begin
          stall_cnt_d = stall_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every side effect of a transfer happens only in the single cycle where
  // psel, penable and pready are all high.
  assign commit    = psel & penable & pready;
  assign wr_cmd    = commit & pwrite & dec.mapped & (dec.idx == REG_CMD);
  assign wr_status = commit & pwrite & dec.mapped & (dec.idx == REG_STATUS);
  assign wr_cfg    = commit & pwrite & dec.mapped & (dec.idx == REG_CFG);
  assign wr_fifo   = commit & pwrite & dec.mapped & (dec.idx == REG_FIFO);
  assign fifo_push = wr_fifo & ~drop;

  always_comb begin
    cmd_d = wr_cmd ? pwdata[7:0] : 8'h00;
    cfg_d = wr_cfg ? pwdata : cfg_q;
    ovf_d = ovf_q;
    if (drop)                                 ovf_d = 1'b1;
    else if (wr_status && pwdata[STAT_OVF_BIT]) ovf_d = 1'b0;
  end

  always_comb begin
    status                 = '0;
    status[4:0]            = 5'(fifo_level);
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_OVF_BIT]   = ovf_q;
  end

  always_comb begin
    prdata = '0;
    if (commit && !pwrite && dec.mapped) begin
      case (dec.idx)
        REG_STATUS: prdata = status;
        REG_CFG:    prdata = cfg_q;
        default:    prdata = '0;
      endcase
    end
  end

`ifdef APB_SLVERR_EN
  assign pslverr = commit & (~dec.mapped | drop |
                   (wr_status & (|(pwdata & ~STATUS_W1C_MASK))));
`else
  assign pslverr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      cfg_q       <= '0;
      cmd_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      cfg_q       <= cfg_d;
      cmd_q       <= cmd_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (pwdata),
    .pop_i   (ready_i),
    .head_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign valid_o = ~fifo_empty;
  assign cmd_o   = cmd_q;
  assign cfg_o   = cfg_q;
  assign state_o = state_q;

endmodule
